// File: rtl/fetch_unit_if.sv
// Fetch unit bus: instruction-memory address/data plus the decode-side
// handshake (stall/redirect in, instruction/address/valid out).
// master: the fetch unit itself. slave: memory/decode environment.
interface fetch_unit_if;
    logic [31:0] Pc;
    logic [31:0] InstReg;
    logic        Stall;
    logic        Redirect;
    logic [31:0] RedirectPc;
    logic [31:0] Inst;
    logic [31:0] InstPc;
    logic [31:0] InstPcPlus4;
    logic        InstValid;
    logic        AlignErr;

    modport master (
        output Pc,
        input  InstReg,
        input  Stall,
        input  Redirect,
        input  RedirectPc,
        output Inst,
        output InstPc,
        output InstPcPlus4,
        output InstValid,
        output AlignErr
    );

    modport slave (
        input  Pc,
        output InstReg,
        output Stall,
        output Redirect,
        output RedirectPc,
        input  Inst,
        input  InstPc,
        input  InstPcPlus4,
        input  InstValid,
        input  AlignErr
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage. Drives a registered PC to a one-cycle-latency
// instruction memory, tags the returning word with its address and skids it
// into a hold register while decode stalls. Redirects flush in-flight work.
// Optional macro FETCH_PERF_CNT_EN adds FetchCount/BubbleCount outputs.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        Clk,
    input  logic        Rst_n,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] FetchCount,
    output logic [31:0] BubbleCount,
`endif
    fetch_unit_if.master bus
);

    localparam logic [31:0] STEP = 32'(PC_STEP);

    logic [31:0] r_pc;
    logic [31:0] r_flight_pc;
    logic        r_flight_valid;
    logic [31:0] r_hold_inst;
    logic        r_hold_valid;
    logic        r_align_err;

    logic        w_advance;

    assign w_advance = !bus.Redirect && !bus.Stall;

    // PC, in-flight tag, skid register and sticky alignment flag.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_pc           <= RESET_PC;
            r_flight_pc    <= RESET_PC;
            r_flight_valid <= 1'b0;
            r_hold_inst    <= 32'h0;
            r_hold_valid   <= 1'b0;
            r_align_err    <= 1'b0;
        end else if (bus.Redirect) begin
            // Redirect beats stall: drop the in-flight word and any held word.
            r_pc           <= {bus.RedirectPc[31:2], 2'b00};
            r_flight_valid <= 1'b0;
            r_hold_valid   <= 1'b0;
            if (bus.RedirectPc[1:0] != 2'b00) begin
                r_align_err <= 1'b1;
            end
        end else if (!bus.Stall) begin
            r_flight_pc    <= r_pc;
            r_flight_valid <= 1'b1;
            r_pc           <= r_pc + STEP;
            r_hold_valid   <= 1'b0;
        end else if (!r_hold_valid && r_flight_valid) begin
            // First stalled edge: memory output is about to move on, so keep it.
            r_hold_inst  <= bus.InstReg;
            r_hold_valid <= 1'b1;
        end
    end

    // Decode-facing outputs straight from state; no extra latency.
    always_comb begin
        bus.Pc          = r_pc;
        bus.Inst        = r_hold_valid ? r_hold_inst : bus.InstReg;
        bus.InstPc      = r_flight_pc;
        bus.InstPcPlus4 = r_flight_pc + STEP;
        bus.InstValid   = r_flight_valid;
        bus.AlignErr    = r_align_err;
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_bubble_cnt;

    // Count delivered instructions and empty slots; stalled valid cycles count as neither.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_fetch_cnt  <= 32'h0;
            r_bubble_cnt <= 32'h0;
        end else begin
            if (w_advance && r_flight_valid) begin
                r_fetch_cnt <= r_fetch_cnt + 32'h1;
            end
            if (!r_flight_valid) begin
                r_bubble_cnt <= r_bubble_cnt + 32'h1;
            end
        end
    end

    assign FetchCount  = r_fetch_cnt;
    assign BubbleCount = r_bubble_cnt;
`else
    logic w_unused;
    assign w_unused = w_advance;
`endif

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, fetch address loaded on reset.
REQ-002 Parameter: PC_STEP, 4, byte increment between sequential fetches.
REQ-003 Port: Clk  input  1  single clock; all state updates on posedge.
REQ-004 Port: Rst_n  input  1  reset, synchronous, active-low.
REQ-005 Port: Pc  output  32  registered fetch address driven to the instruction memory, which returns IMemory[Pc>>2] on InstReg one posedge later.
REQ-006 Port: InstReg  input  32  instruction word returned by the instruction memory.
REQ-007 Port: Stall  input  1  decode cannot accept the presented instruction this cycle.
REQ-008 Port: Redirect  input  1  taken branch/jump; discard in-flight work and refetch.
REQ-009 Port: RedirectPc  input  32  target address for Redirect.
REQ-010 Port: Inst  output  32  instruction presented to decode.
REQ-011 Port: InstPc  output  32  address of Inst.
REQ-012 Port: InstPcPlus4  output  32  InstPc+PC_STEP, modulo 2^32.
REQ-013 Port: InstValid  output  1  Inst/InstPc are meaningful this cycle.
REQ-014 Port: AlignErr  output  1  sticky flag, set when a redirect target is not word-aligned.

Function
REQ-015 Internal state: PcReg (drives Pc), FlightPc, FlightValid (tags the word arriving on InstReg), HoldInst, HoldValid (skid register).
REQ-016 Advance condition: Redirect=0 and Stall=0; on advance, FlightPc<=PcReg, FlightValid<=1, PcReg<=PcReg+PC_STEP (wraps at 2^32), HoldValid<=0.
REQ-017 Outputs: Inst=HoldValid?HoldInst:InstReg; InstPc=FlightPc; InstValid=FlightValid; all are combinational from registers and InstReg, with no added latency.
REQ-018 Stall=1 and Redirect=0: PcReg, FlightPc and FlightValid hold; if HoldValid=0 and FlightValid=1, then HoldInst<=InstReg and HoldValid<=1; if HoldValid=1, the hold register is retained unchanged.
REQ-019 While stalled, Inst, InstPc and InstValid stay stable every cycle.
REQ-020 Stall release: the held word is consumed on the first unstalled posedge; the next cycle presents InstReg=I(old PcReg) tagged FlightPc=old PcReg, so no instruction is lost or duplicated.
REQ-021 Redirect=1 (priority over Stall): PcReg<={RedirectPc[31:2],2'b00}, FlightValid<=0, HoldValid<=0.
REQ-022 Redirect=1 with RedirectPc[1:0]!=0 sets AlignErr<=1; AlignErr clears only on reset.
REQ-023 Redirect penalty: exactly one InstValid=0 cycle follows the redirect edge; the target instruction is valid on the second cycle after that edge.
REQ-024 Back-to-back redirects: the last one wins, and each redirect edge restarts the one-bubble sequence.
REQ-025 Stall with FlightValid=0: nothing is captured, and PcReg holds.

Reset
REQ-026 Rst_n=0 at posedge: PcReg<=RESET_PC, FlightPc<=RESET_PC, FlightValid<=0, HoldValid<=0, HoldInst<=0, AlignErr<=0.
REQ-027 Reset overrides Stall and Redirect.
REQ-028 First cycle after reset: InstValid=0 and Pc=RESET_PC; InstValid=1 with InstPc=RESET_PC on the second cycle.
REQ-029 Reset asserted mid-stall or mid-redirect discards all held and in-flight state.

Configuration
REQ-030 Macro FETCH_PERF_CNT_EN defined: adds outputs FetchCount[31:0] (increments on each advance edge with InstValid=1) and BubbleCount[31:0] (increments on each edge with InstValid=0 and Rst_n=1).
REQ-031 FETCH_PERF_CNT_EN counter behaviour: both counters reset to 0, wrap at 2^32, and do not count during stalls with InstValid=1.
REQ-032 Macro FETCH_PERF_CNT_EN not defined: these ports and counters are absent, and all other behaviour is identical.

Verification
REQ-033 Reset then 6 free-running cycles, RESET_PC=0 -> Pc sequence 0,4,8,12,...; InstPc 0,4,8,... starting the second cycle; Inst matches the memory image.
REQ-034 Stall=1 for 3 cycles while presenting InstPc=8 -> Inst=I(8), InstPc=8 stable for 3 cycles; after release InstPc=12 then 16, no gaps or duplicates.
REQ-035 Redirect=1 with RedirectPc=0x40 while InstPc=0x10 -> one InstValid=0 cycle, then InstPc=0x40, 0x44.
REQ-036 Redirect and Stall in the same cycle with RedirectPc=0x81 -> redirect wins; InstPc=0x80 after the bubble; AlignErr=1 until reset.
REQ-037 PcReg=0xFFFF_FFFC advancing -> next Pc=0x0000_0000 and InstPcPlus4=0 for InstPc=0xFFFF_FFFC.
REQ-038 FETCH_PERF_CNT_EN defined: 10 cycles after reset with one redirect and a 2-cycle stall -> FetchCount and BubbleCount match a reference-model count exactly.
